// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 method.
// One binary bit is shifted into the BCD work register per clock. Before
// each shift, every BCD digit of 5..9 gets +3 so the shift yields a valid
// decimal carry. The packed result is published on bcd_out with a one-cycle
// done pulse and is held until the next conversion completes.
module bin_to_bcd_seq #(
   parameter int IN_W   = 6,
   parameter int DIGITS = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t              state_q,    state_d;
   logic [IN_W-1:0]     bin_sh_q,   bin_sh_d;
   logic [BCD_W-1:0]    bcd_work_q, bcd_work_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic [BCD_W-1:0]    bcd_out_q,  bcd_out_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;

   logic [BCD_W-1:0]    corr_bcd;
   logic [BCD_W-1:0]    shift_bcd;

   // Add-3 correction for one digit. Digits 10..15 never occur because the
   // work register always holds valid BCD; they map to 0 as a safe default.
   function automatic logic [3:0] add3_fix(input logic [3:0] d);
      logic [3:0] r;
      case (d)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4: r = d;
         4'd5, 4'd6, 4'd7, 4'd8, 4'd9: r = d + 4'd3;
         default:                      r = 4'd0;
      endcase
      return r;
   endfunction

   // Apply the per-digit correction, then form the left-shifted BCD value
   // with the binary MSB entering digit 0.
   always_comb begin
      corr_bcd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         corr_bcd[4*i +: 4] = add3_fix(bcd_work_q[4*i +: 4]);
      end
      shift_bcd = {corr_bcd[BCD_W-2:0], bin_sh_q[IN_W-1]};
   end

   // Next-state and next-output logic of the IDLE/SHIFT controller.
   always_comb begin
      state_d    = state_q;
      bin_sh_d   = bin_sh_q;
      bcd_work_d = bcd_work_q;
      cnt_d      = cnt_q;
      bcd_out_d  = bcd_out_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bin_sh_d   = bin_in;
               bcd_work_d = '0;
               cnt_d      = CNT_W'(IN_W);
               busy_d     = 1'b1;
               state_d    = ST_SHIFT;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            bin_sh_d   = bin_sh_q << 1;
            bcd_work_d = shift_bcd;
            cnt_d      = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Last bit shifted in: publish and return to IDLE.
               bcd_out_d = shift_bcd;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               state_d   = ST_SHIFT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; synchronous reset aborts any conversion.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         bin_sh_q   <= '0;
         bcd_work_q <= '0;
         cnt_q      <= '0;
         bcd_out_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_sh_q   <= bin_sh_d;
         bcd_work_q <= bcd_work_d;
         cnt_q      <= cnt_d;
         bcd_out_q  <= bcd_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcd_out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default build (6 bit, 2 digits)
// and a wide build (8 bit, 3 digits). Expected results are queued when a
// conversion is started and compared when done is observed.
module tb_bin_to_bcd_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  bin_in = '0;
   logic        busy;
   logic        done;
   logic [7:0]  bcd_out;

   logic        start2 = 1'b0;
   logic [7:0]  bin2 = '0;
   logic        busy2;
   logic        done2;
   logic [11:0] bcd2;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0]  q1[$];
   logic [11:0] q2[$];

   typedef struct {
      logic [5:0] val;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic [7:0]  val;
      logic [11:0] exp;
   } vec2_t;

   bin_to_bcd_seq #(.IN_W(6), .DIGITS(2)) dut (
      .CLK(CLK), .RST(RST), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out)
   );

   bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) dut_w (
      .CLK(CLK), .RST(RST), .start(start2), .bin_in(bin2),
      .busy(busy2), .done(done2), .bcd_out(bcd2)
   );

   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [11:0] ref_bcd(input int v);
      logic [11:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   // Scoreboard for the default build: pop on each done pulse.
   always @(negedge CLK) begin
      if (done === 1'b1) begin
         total_cnt++;
         if (q1.size() == 0) begin
            $display("FAIL unexpected_done: got bcd %0h with nothing expected", bcd_out);
         end else begin
            logic [7:0] e;
            e = q1.pop_front();
            if (bcd_out === e) pass_cnt++;
            else $display("FAIL bcd_out: got %0h expected %0h", bcd_out, e);
         end
      end
   end

   // Scoreboard for the wide build.
   always @(negedge CLK) begin
      if (done2 === 1'b1) begin
         total_cnt++;
         if (q2.size() == 0) begin
            $display("FAIL unexpected_done2: got bcd %0h with nothing expected", bcd2);
         end else begin
            logic [11:0] e;
            e = q2.pop_front();
            if (bcd2 === e) pass_cnt++;
            else $display("FAIL bcd_out2: got %0h expected %0h", bcd2, e);
         end
      end
   end

   // One conversion on the default build; checks hold, latency and busy.
   task automatic run1(input logic [5:0] v, input logic [7:0] exp, input bit full);
      int cyc;
      int busy_cyc;
      logic [7:0] prev;
      prev = bcd_out;
      bin_in = v;
      start = 1'b1;
      q1.push_back(exp);
      @(negedge CLK);
      start = 1'b0;
      cyc = 1;
      busy_cyc = 0;
      if (full) check("hold_after_start", 32'(bcd_out), 32'(prev));
      while (done !== 1'b1 && cyc < 20) begin
         if (busy === 1'b1) busy_cyc++;
         @(negedge CLK);
         cyc++;
      end
      if (full) begin
         check("latency", 32'(cyc), 32'd7);
         check("busy_cycles", 32'(busy_cyc), 32'd6);
         check("busy_at_done", 32'(busy), 32'd0);
      end else if (cyc != 7) begin
         check("sweep_latency", 32'(cyc), 32'd7);
      end
   endtask

   task automatic run2(input logic [7:0] v, input logic [11:0] exp);
      int cyc;
      bin2 = v;
      start2 = 1'b1;
      q2.push_back(exp);
      @(negedge CLK);
      start2 = 1'b0;
      cyc = 1;
      while (done2 !== 1'b1 && cyc < 20) begin
         @(negedge CLK);
         cyc++;
      end
      check("latency_w", 32'(cyc), 32'd9);
   endtask

   initial begin
      vec_t  tbl[5];
      vec2_t tbl2[3];
      int d1;
      int d2;
      int ndone;

      tbl[0] = '{6'd0,  8'h00};
      tbl[1] = '{6'd9,  8'h09};
      tbl[2] = '{6'd10, 8'h10};
      tbl[3] = '{6'd45, 8'h45};
      tbl[4] = '{6'd58, 8'h58};
      tbl2[0] = '{8'd255, 12'h255};
      tbl2[1] = '{8'd100, 12'h100};
      tbl2[2] = '{8'd99,  12'h099};

      // Reset state.
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bcd", 32'(bcd_out), 32'd0);
      check("rst_bcd_w", 32'(bcd2), 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      // Full-scale value with timing checks.
      run1(6'd63, 8'h63, 1'b1);

      // Corner table.
      foreach (tbl[i]) run1(tbl[i].val, tbl[i].exp, 1'b1);

      // Exhaustive sweep against the reference model, back to back.
      for (int v = 0; v < 64; v++) run1(6'(v), ref_bcd(v)[7:0], 1'b0);
      repeat (2) @(negedge CLK);

      // start held high, operand changes mid-conversion, restart on done.
      bin_in = 6'd20;
      start = 1'b1;
      q1.push_back(8'h20);
      d1 = 0;
      d2 = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK);
         if (c == 3) bin_in = 6'd55;
         if (done === 1'b1) begin
            if (d1 == 0) d1 = c;
            else if (d2 == 0) d2 = c;
         end
         if (c == 7) q1.push_back(8'h55);
         if (c == 8) start = 1'b0;
      end
      check("hold_first_done", 32'(d1), 32'd7);
      check("restart_second_done", 32'(d2), 32'd14);

      // Start pulse while busy is ignored.
      bin_in = 6'd33;
      start = 1'b1;
      q1.push_back(8'h33);
      ndone = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK);
         start = 1'b0;
         if (c == 2) begin
            bin_in = 6'd7;
            start = 1'b1;
         end
         if (done === 1'b1) ndone++;
      end
      check("busy_start_ignored", 32'(ndone), 32'd1);

      // Reset in the middle of a conversion aborts it.
      bin_in = 6'd37;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_bcd", 32'(bcd_out), 32'd0);
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         if (done === 1'b1) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      run1(6'd37, 8'h37, 1'b1);

      // Wide build.
      foreach (tbl2[i]) run2(tbl2[i].val, tbl2[i].exp);

      repeat (3) @(negedge CLK);
      check("queue1_empty", 32'(q1.size()), 32'd0);
      check("queue2_empty", 32'(q2.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
